// File: rtl/fir_pkg.sv
// Shared FIR constants and types, used by the tap sequencer, the MAC datapath
// and the coefficient ROM.
package fir_pkg;

  localparam int FIR_TAPS   = 32;
  localparam int FIR_AW     = 5;
  localparam int FIR_CW     = 5;
  localparam int FIR_RD_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } firState_e;

  // Tag that travels alongside a tap read while the memories respond
  typedef struct packed {
    logic valid;
    logic first;
  } tapTag_t;

endpackage

// File: rtl/fir_lat_pipe.sv
// Read-latency alignment pipe: delays the per-tap {valid, first} tag by
// RD_LAT cycles so the MAC strobes line up with data at the MAC input.
// Reset also flushes any in-flight taps.
module fir_lat_pipe
  import fir_pkg::*;
#(
  parameter int RD_LAT = FIR_RD_LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic inValid,
  input  logic inFirst,
  output logic macEn,
  output logic macClr
);

  tapTag_t              stage0;
  tapTag_t [RD_LAT:1]   latPipe;

  assign stage0 = '{valid: inValid, first: inFirst};

  // Shift the tag one stage per cycle; reset clears every stage
  always_ff @(posedge clk) begin
    if (reset) begin
      latPipe <= '0;
    end else begin
      latPipe[1] <= stage0;
      for (int i = 2; i <= RD_LAT; i++) latPipe[i] <= latPipe[i-1];
    end
  end

  assign macEn  = latPipe[RD_LAT].valid;
  assign macClr = latPipe[RD_LAT].valid & latPipe[RD_LAT].first;

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR tap address/timing sequencer. Owns the circular delay-line head pointer,
// accepts samples while idle, and on fir_start walks every tap emitting
// coefficient and sample read addresses plus latency-aligned MAC strobes.
// Optional build macro FIR_SYMMETRIC_EN: linear-phase folding, half the issue
// cycles and a second sample read address samp_raddr2 (TAPS must be even).
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS   = FIR_TAPS,
  parameter int AW     = FIR_AW,
  parameter int CW     = FIR_CW,
  parameter int RD_LAT = FIR_RD_LAT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fir_start,
  input  logic          samp_valid,
  output logic          samp_ready,
  output logic          samp_we,
  output logic [AW-1:0] samp_waddr,
  output logic [AW-1:0] samp_raddr,
  output logic [CW-1:0] coef_addr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          fir_end,
  output logic          busy
`ifdef FIR_SYMMETRIC_EN
  ,
  output logic [AW-1:0] samp_raddr2
`endif
);

`ifdef FIR_SYMMETRIC_EN
  // Folded filter: each issue cycle reads the pair of samples sharing a coefficient
  localparam int ISSUE_LEN = TAPS / 2;
`else
  localparam int ISSUE_LEN = TAPS;
`endif
  localparam logic [CW-1:0] LAST_K = CW'(ISSUE_LEN - 1);
  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DW-1:0] LAST_D = DW'(RD_LAT - 1);

  firState_e     state, stateNxt;
  logic [AW-1:0] head, headNxt;
  logic [CW-1:0] k, kNxt;
  logic [DW-1:0] dcnt, dcntNxt;
  logic          inIssue;
  logic          sampWe;

  assign inIssue = (state == ISSUE);

  // Sample port handshake: writes only accepted while idle
  assign samp_ready = (state == IDLE);
  assign sampWe     = samp_valid & samp_ready;
  assign samp_we    = sampWe;
  assign samp_waddr = head + AW'(1);

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      head  <= '0;
      k     <= '0;
      dcnt  <= '0;
    end else begin
      state <= stateNxt;
      head  <= headNxt;
      k     <= kNxt;
      dcnt  <= dcntNxt;
    end
  end

  // Next-state, tap counter and drain counter; a write and a start in the
  // same idle cycle both land, so the pass sees the new sample as tap 0
  always_comb begin
    stateNxt = state;
    kNxt     = k;
    dcntNxt  = dcnt;
    headNxt  = sampWe ? head + AW'(1) : head;
    case (state)
      IDLE: begin
        if (fir_start) begin
          stateNxt = ISSUE;
          kNxt     = '0;
        end
      end
      ISSUE: begin
        if (k == LAST_K) begin
          stateNxt = DRAIN;
          kNxt     = '0;
          dcntNxt  = '0;
        end else begin
          kNxt = k + CW'(1);
        end
      end
      DRAIN: begin
        if (dcnt == LAST_D) stateNxt = DONE;
        else                dcntNxt  = dcnt + DW'(1);
      end
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Read addresses decoded from registered state; parked at 0 outside ISSUE
  assign coef_addr  = inIssue ? k : '0;
  assign samp_raddr = inIssue ? head - AW'(k) : '0;
`ifdef FIR_SYMMETRIC_EN
  assign samp_raddr2 = inIssue ? head - AW'(TAPS - 1) + AW'(k) : '0;
`endif

  assign fir_end = (state == DONE);
  assign busy    = (state != IDLE);

  fir_lat_pipe #(.RD_LAT(RD_LAT)) uLatPipe (
    .clk     (clk),
    .reset   (reset),
    .inValid (inIssue),
    .inFirst (inIssue && (k == '0)),
    .macEn   (mac_en),
    .macClr  (mac_clr)
  );

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with TAPS=4, AW=3, CW=2, RD_LAT=2.
// Inputs are driven at the falling edge; outputs are checked 1 ns later.
module tb_fir_tap_sequencer;

  localparam int TAPS   = 4;
  localparam int AW     = 3;
  localparam int CW     = 2;
  localparam int RD_LAT = 2;
`ifdef FIR_SYMMETRIC_EN
  localparam int ISSUE_LEN = TAPS / 2;
`else
  localparam int ISSUE_LEN = TAPS;
`endif

  logic          clk = 1'b0;
  logic          reset, fir_start, samp_valid;
  logic          samp_ready, samp_we, mac_clr, mac_en, fir_end, busy;
  logic [AW-1:0] samp_waddr, samp_raddr;
  logic [CW-1:0] coef_addr;
`ifdef FIR_SYMMETRIC_EN
  logic [AW-1:0] samp_raddr2;
`endif

  int nVec = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  fir_tap_sequencer #(.TAPS(TAPS), .AW(AW), .CW(CW), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .fir_start  (fir_start),
    .samp_valid (samp_valid),
    .samp_ready (samp_ready),
    .samp_we    (samp_we),
    .samp_waddr (samp_waddr),
    .samp_raddr (samp_raddr),
    .coef_addr  (coef_addr),
    .mac_clr    (mac_clr),
    .mac_en     (mac_en),
    .fir_end    (fir_end),
    .busy       (busy)
`ifdef FIR_SYMMETRIC_EN
    ,
    .samp_raddr2(samp_raddr2)
`endif
  );

  typedef struct {
    logic          rst, v, s;
    logic          ready, we;
    logic [AW-1:0] waddr, raddr, raddr2;
    logic [CW-1:0] coef;
    logic          clr, en, fend, busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic v, logic s, logic ready, logic we,
                              logic [AW-1:0] waddr, logic [AW-1:0] raddr, logic [CW-1:0] coef,
                              logic clr, logic en, logic fend, logic bsy);
    vec_t r;
    r.rst = rst; r.v = v; r.s = s; r.ready = ready; r.we = we;
    r.waddr = waddr; r.raddr = raddr; r.raddr2 = '0; r.coef = coef;
    r.clr = clr; r.en = en; r.fend = fend; r.busy = bsy;
    return r;
  endfunction

  // Expected outputs c cycles after the start edge, for a pass over head hh.
  // With noise set, samp_valid and fir_start are held high while busy.
  function automatic vec_t expRow(int c, logic [AW-1:0] hh, bit noise);
    vec_t          r;
    int            last;
    bit            issue;
    logic [AW-1:0] kk;
    last  = ISSUE_LEN + RD_LAT + 1;
    issue = (c >= 1) && (c <= ISSUE_LEN);
    kk    = AW'(c - 1);
    r.rst    = 1'b0;
    r.busy   = (c <= last);
    r.v      = noise && r.busy;
    r.s      = r.v;
    r.ready  = !r.busy;
    r.we     = 1'b0;
    r.waddr  = hh + AW'(1);
    r.raddr  = issue ? hh - kk : '0;
    r.raddr2 = issue ? hh - AW'(TAPS - 1) + kk : '0;
    r.coef   = issue ? CW'(c - 1) : '0;
    r.clr    = (c == 1 + RD_LAT);
    r.en     = (c >= 1 + RD_LAT) && (c <= ISSUE_LEN + RD_LAT);
    r.fend   = (c == last);
    return r;
  endfunction

  task automatic check(string nm, int act, int exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs, advance to the next falling edge
  task automatic cyc(input vec_t r);
    reset      = r.rst;
    samp_valid = r.v;
    fir_start  = r.s;
    #1;
    check("samp_ready", int'(samp_ready), int'(r.ready));
    check("samp_we",    int'(samp_we),    int'(r.we));
    check("samp_waddr", int'(samp_waddr), int'(r.waddr));
    check("samp_raddr", int'(samp_raddr), int'(r.raddr));
    check("coef_addr",  int'(coef_addr),  int'(r.coef));
    check("mac_clr",    int'(mac_clr),    int'(r.clr));
    check("mac_en",     int'(mac_en),     int'(r.en));
    check("fir_end",    int'(fir_end),    int'(r.fend));
    check("busy",       int'(busy),       int'(r.busy));
`ifdef FIR_SYMMETRIC_EN
    check("samp_raddr2", int'(samp_raddr2), int'(r.raddr2));
`endif
    @(negedge clk);
  endtask

  task automatic wrSample(logic [AW-1:0] wa);
    cyc(mk(0, 1, 0, 1, 1, wa, 0, 0, 0, 0, 0, 0));
  endtask

  // Full pass from idle: start cycle (optionally with a write) then every cycle
  // through to the first idle cycle after fir_end
  task automatic doPass(logic [AW-1:0] h0, bit wr, bit noise);
    logic [AW-1:0] hh;
    hh = wr ? h0 + AW'(1) : h0;
    cyc(mk(0, wr, 1, 1, wr, h0 + AW'(1), 0, 0, 0, 0, 0, 0));
    for (int c = 1; c <= ISSUE_LEN + RD_LAT + 2; c++) cyc(expRow(c, hh, noise));
  endtask

  initial begin
    vec_t r;
    reset = 1'b1; samp_valid = 1'b0; fir_start = 1'b0;
    repeat (2) @(negedge clk);

    // reset state, three sample writes, then a pass over head=3
    tbl.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0));
`ifndef FIR_SYMMETRIC_EN
    tbl.push_back(mk(0, 0, 1, 1, 0, 4, 0, 0, 0, 0, 0, 0)); // t
    tbl.push_back(mk(0, 0, 0, 0, 0, 4, 3, 0, 0, 0, 0, 1)); // t+1
    tbl.push_back(mk(0, 0, 0, 0, 0, 4, 2, 1, 0, 0, 0, 1)); // t+2
    tbl.push_back(mk(0, 0, 0, 0, 0, 4, 1, 2, 1, 1, 0, 1)); // t+3
    tbl.push_back(mk(0, 0, 0, 0, 0, 4, 0, 3, 0, 1, 0, 1)); // t+4
    tbl.push_back(mk(0, 0, 0, 0, 0, 4, 0, 0, 0, 1, 0, 1)); // t+5
    tbl.push_back(mk(0, 0, 0, 0, 0, 4, 0, 0, 0, 1, 0, 1)); // t+6
    tbl.push_back(mk(0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 1, 1)); // t+7
    tbl.push_back(mk(0, 0, 0, 1, 0, 4, 0, 0, 0, 0, 0, 0)); // t+8
`endif
    foreach (tbl[i]) cyc(tbl[i]);
`ifdef FIR_SYMMETRIC_EN
    doPass(3'd3, 1'b0, 1'b0);
`endif

    // six writes take head 3 -> 1 through the wrap, then a wrapping pass
    for (int i = 0; i < 6; i++) wrSample(AW'(4 + i));
    doPass(3'd1, 1'b0, 1'b0);

    // head 1 -> 5, then write and start in the same cycle
    for (int i = 0; i < 4; i++) wrSample(AW'(2 + i));
    doPass(3'd5, 1'b1, 1'b0);

    // head=6: writes and starts while busy are refused and ignored
    doPass(3'd6, 1'b0, 1'b1);

    // reset at t+3 aborts the pass: no more strobes, no fir_end, head back to 0
    cyc(mk(0, 0, 1, 1, 0, 7, 0, 0, 0, 0, 0, 0));
    cyc(expRow(1, 3'd6, 1'b0));
    cyc(expRow(2, 3'd6, 1'b0));
    r = expRow(3, 3'd6, 1'b0);
    r.rst = 1'b1;
    cyc(r);
    for (int i = 0; i < 6; i++) cyc(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
